// File: rtl/sha256_pkg.sv
// Shared constants and enumerations for the SHA-256 message fetch/padding path.
package sha256_pkg;

  localparam int unsigned BLOCK_BYTES     = 32'd64;
  localparam int unsigned WORD_BYTES      = 32'd4;
  localparam int unsigned LEN_FIELD_BYTES = 32'd8;
  localparam logic [7:0]  PAD_BYTE        = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_MEM  = 2'd0,
    SRC_PAD  = 2'd1,
    SRC_ZERO = 2'd2,
    SRC_LEN  = 2'd3
  } byte_src_t;

endpackage

// File: rtl/pad_byte_sel.sv
// Decides where the byte at padded position p comes from and, for the trailing
// length field, which byte of the 64-bit bit count it is.
module pad_byte_sel
  import sha256_pkg::*;
#(
  parameter int AW = 7,
  parameter int PW = 14
) (
  input  logic [PW-1:0] p,
  input  logic [AW-1:0] l,
  input  logic [PW-1:0] t,
  output byte_src_t     src,
  output logic [7:0]    len_byte
);

  logic [PW-1:0] l_ext_s;
  logic [63:0]   len_bits_s;
  logic [2:0]    len_idx_s;

  assign l_ext_s    = PW'(l);
  assign len_bits_s = 64'(l) << 3;
  // T is a multiple of 8, so the offset inside the length field is just p mod 8
  assign len_idx_s  = p[2:0];

  // Byte-source classification of position p
  always_comb begin
    src = SRC_ZERO;
    if (p < l_ext_s) begin
      src = SRC_MEM;
    end else if (p == l_ext_s) begin
      src = SRC_PAD;
    end else if (p >= (t - PW'(LEN_FIELD_BYTES))) begin
      src = SRC_LEN;
    end else begin
      src = SRC_ZERO;
    end
  end

  // Length byte, most significant byte first
  always_comb begin
    len_byte = len_bits_s[{3'd7 - len_idx_s, 3'b000} +: 8];
  end

endmodule

// File: rtl/msg_pad_fetch.sv
// SHA-256 message fetch and padding engine: streams padded big-endian words,
// 16 per block, fetching message bytes through a one-cycle-latency byte memory.
module msg_pad_fetch
  import sha256_pkg::*;
#(
  parameter  int MAX_MESSAGE_LENGTH = 55,
  localparam int AW = $clog2(MAX_MESSAGE_LENGTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] msg_length,
  output logic          read_en,
  output logic [AW-1:0] read_address,
  input  logic [7:0]    read_data,
  output logic          word_valid,
  input  logic          word_ready,
  output logic [31:0]   word_data,
  output logic [3:0]    word_index,
  output logic          block_last,
  output logic          busy,
  output logic          done,
  output logic          len_error
);

  localparam int PW = AW + 7;
  localparam logic [AW-1:0] MAX_LEN = AW'(MAX_MESSAGE_LENGTH);

  state_t        state_r, state_s;
  logic [AW-1:0] len_r;
  logic [PW-1:0] issue_pos_r;
  logic          iss_v_r, cap_v_r;
  byte_src_t     src_r, cap_src_r, src_s;
  logic [7:0]    len_byte_r, cap_len_byte_r, len_byte_s;
  logic [1:0]    cap_cnt_r;

  logic          read_en_r, word_valid_r, block_last_r, busy_r, done_r, len_error_r;
  logic [AW-1:0] read_address_r;
  logic [31:0]   word_data_r;
  logic [3:0]    word_index_r;

  logic          word_valid_s, block_last_s, busy_s, done_s, len_error_s;
  logic [3:0]    word_index_s;

  logic          accept_s, reject_s, xfer_s, final_s, issue_s, word_done_s;
  logic [AW-1:0] l_eff_s;
  logic [PW-1:0] pos_s, t_s;
  logic [31:0]   l_wide_s;
  logic [7:0]    cap_byte_s;

  assign accept_s    = (state_r == IDLE) && start && (msg_length <= MAX_LEN);
  assign reject_s    = (state_r == IDLE) && start && (msg_length > MAX_LEN);
  assign xfer_s      = (state_r == HOLD) && word_valid_r && word_ready;
  assign final_s     = (issue_pos_r == t_s);
  assign word_done_s = cap_v_r && (cap_cnt_r == 2'd3);
  // In IDLE the first position is issued on the same edge that latches L
  assign l_eff_s     = (state_r == IDLE) ? msg_length : len_r;
  assign pos_s       = (state_r == IDLE) ? {PW{1'b0}} : issue_pos_r;
  assign issue_s     = accept_s
                     || ((state_r == FILL) && (issue_pos_r[1:0] != 2'b00))
                     || (xfer_s && !final_s);
  assign l_wide_s    = 32'(l_eff_s);
  assign t_s         = PW'(((l_wide_s + LEN_FIELD_BYTES) / BLOCK_BYTES + 32'd1) * BLOCK_BYTES);

  pad_byte_sel #(.AW(AW), .PW(PW)) u_sel (
    .p        (pos_s),
    .l        (l_eff_s),
    .t        (t_s),
    .src      (src_s),
    .len_byte (len_byte_s)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_s = FILL; else state_s = IDLE;
      FILL:    if (word_done_s) state_s = HOLD; else state_s = FILL;
      HOLD: begin
        if (xfer_s) begin
          if (final_s) state_s = IDLE; else state_s = FILL;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered handshake and status outputs
  always_comb begin
    word_valid_s = word_valid_r;
    block_last_s = block_last_r;
    word_index_s = word_index_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    len_error_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          busy_s       = 1'b1;
          word_index_s = 4'd0;
        end else if (reject_s) begin
          len_error_s = 1'b1;
        end else begin
          busy_s = 1'b0;
        end
      end
      FILL: begin
        if (word_done_s) begin
          word_valid_s = 1'b1;
          block_last_s = final_s;
        end else begin
          word_valid_s = 1'b0;
        end
      end
      HOLD: begin
        if (xfer_s) begin
          word_valid_s = 1'b0;
          block_last_s = 1'b0;
          if (final_s) begin
            busy_s = 1'b0;
            done_s = 1'b1;
          end else begin
            word_index_s = word_index_r + 4'd1;
          end
        end else begin
          word_valid_s = 1'b1;
        end
      end
      default: begin
        word_valid_s = 1'b0;
        block_last_s = 1'b0;
        word_index_s = 4'd0;
        busy_s       = 1'b0;
      end
    endcase
  end

  // Registered handshake and status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_valid_r <= 1'b0;
      block_last_r <= 1'b0;
      word_index_r <= 4'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      len_error_r  <= 1'b0;
    end else begin
      word_valid_r <= word_valid_s;
      block_last_r <= block_last_s;
      word_index_r <= word_index_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      len_error_r  <= len_error_s;
    end
  end

  // Issue stage: memory strobe plus the byte source travelling alongside it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      iss_v_r        <= 1'b0;
      read_en_r      <= 1'b0;
      read_address_r <= {AW{1'b0}};
      src_r          <= SRC_ZERO;
      len_byte_r     <= 8'h00;
      issue_pos_r    <= {PW{1'b0}};
      len_r          <= {AW{1'b0}};
    end else begin
      iss_v_r   <= issue_s;
      read_en_r <= issue_s && (src_s == SRC_MEM);
      if (issue_s) begin
        read_address_r <= pos_s[AW-1:0];
        src_r          <= src_s;
        len_byte_r     <= len_byte_s;
        issue_pos_r    <= pos_s + PW'(1);
      end else begin
        read_address_r <= read_address_r;
        src_r          <= src_r;
        len_byte_r     <= len_byte_r;
        issue_pos_r    <= issue_pos_r;
      end
      if (accept_s) begin
        len_r <= msg_length;
      end else begin
        len_r <= len_r;
      end
    end
  end

  // Delay stage matching the memory read latency for every byte source
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cap_v_r        <= 1'b0;
      cap_src_r      <= SRC_ZERO;
      cap_len_byte_r <= 8'h00;
    end else begin
      cap_v_r        <= iss_v_r;
      cap_src_r      <= src_r;
      cap_len_byte_r <= len_byte_r;
    end
  end

  // Byte selected for capture
  always_comb begin
    cap_byte_s = 8'h00;
    case (cap_src_r)
      SRC_MEM:  cap_byte_s = read_data;
      SRC_PAD:  cap_byte_s = PAD_BYTE;
      SRC_LEN:  cap_byte_s = cap_len_byte_r;
      SRC_ZERO: cap_byte_s = 8'h00;
      default:  cap_byte_s = 8'h00;
    endcase
  end

  // Word assembly, first byte ends up most significant
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_data_r <= 32'h0000_0000;
      cap_cnt_r   <= 2'd0;
    end else if (cap_v_r) begin
      word_data_r <= {word_data_r[23:0], cap_byte_s};
      cap_cnt_r   <= cap_cnt_r + 2'd1;
    end else begin
      word_data_r <= word_data_r;
      cap_cnt_r   <= cap_cnt_r;
    end
  end

  assign read_en      = read_en_r;
  assign read_address = read_address_r;
  assign word_valid   = word_valid_r;
  assign word_data    = word_data_r;
  assign word_index   = word_index_r;
  assign block_last   = block_last_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign len_error    = len_error_r;

endmodule

// File: tb/tb_msg_pad_fetch.sv
// Directed bench for msg_pad_fetch: one instance at MAX=55, one at MAX=119.
module tb_msg_pad_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        word_ready;
  logic        a_start, b_start;
  logic [6:0]  a_len;
  logic [7:0]  b_len;

  logic        a_read_en, a_word_valid, a_block_last, a_busy, a_done, a_len_error;
  logic [6:0]  a_read_address;
  logic [7:0]  a_read_data;
  logic [31:0] a_word_data;
  logic [3:0]  a_word_index;
  logic        b_read_en, b_word_valid, b_block_last, b_busy, b_done, b_len_error;
  logic [7:0]  b_read_address;
  logic [7:0]  b_read_data;
  logic [31:0] b_word_data;
  logic [3:0]  b_word_index;

  logic        c_read_en, c_word_valid, c_block_last, c_busy, c_done;
  logic [31:0] c_word_data;
  logic [3:0]  c_word_index;

  logic [7:0]  mem [0:255];
  logic [31:0] got_word [0:63];
  logic [3:0]  got_idx [0:63];
  int          sel = 0;
  int          nwords, nreads, ndone, first_lat;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  msg_pad_fetch #(.MAX_MESSAGE_LENGTH(55)) dut_a (
    .clock(clock), .reset(reset), .start(a_start), .msg_length(a_len),
    .read_en(a_read_en), .read_address(a_read_address), .read_data(a_read_data),
    .word_valid(a_word_valid), .word_ready(word_ready), .word_data(a_word_data),
    .word_index(a_word_index), .block_last(a_block_last), .busy(a_busy),
    .done(a_done), .len_error(a_len_error)
  );

  msg_pad_fetch #(.MAX_MESSAGE_LENGTH(119)) dut_b (
    .clock(clock), .reset(reset), .start(b_start), .msg_length(b_len),
    .read_en(b_read_en), .read_address(b_read_address), .read_data(b_read_data),
    .word_valid(b_word_valid), .word_ready(word_ready), .word_data(b_word_data),
    .word_index(b_word_index), .block_last(b_block_last), .busy(b_busy),
    .done(b_done), .len_error(b_len_error)
  );

  // Byte memories with one cycle of read latency; unread cycles return a marker
  always @(posedge clock) begin
    a_read_data <= a_read_en ? mem[a_read_address] : 8'hEE;
    b_read_data <= b_read_en ? mem[b_read_address] : 8'hEE;
  end

  always_comb begin
    c_read_en    = (sel != 0) ? b_read_en    : a_read_en;
    c_word_valid = (sel != 0) ? b_word_valid : a_word_valid;
    c_block_last = (sel != 0) ? b_block_last : a_block_last;
    c_busy       = (sel != 0) ? b_busy       : a_busy;
    c_done       = (sel != 0) ? b_done       : a_done;
    c_word_data  = (sel != 0) ? b_word_data  : a_word_data;
    c_word_index = (sel != 0) ? b_word_index : a_word_index;
  end

  // Starts one message and follows it to done (or to a mid-stream reset)
  task automatic run_stream(input int which, input int len, input int stall_at, input int abort_at);
    logic [7:0]  pad [0:127];
    logic [31:0] held, exp_word;
    logic        want_done, finished;
    int          total, nbits, stall_left;
    total = 64 * ((len + 8) / 64 + 1);
    nbits = len * 8;
    for (int p = 0; p < 128; p++) pad[p] = 8'h00;
    for (int p = 0; p < len; p++) pad[p] = mem[p];
    pad[len] = 8'h80;
    for (int j = 0; j < 8; j++) pad[total - 1 - j] = 8'(nbits >> (8 * j));
    sel = which; nwords = 0; nreads = 0; ndone = 0; first_lat = -1;
    stall_left = 10; want_done = 1'b0; finished = 1'b0; held = 32'h0;
    @(negedge clock);
    if (which == 0) begin a_start = 1'b1; a_len = 7'(len); end
    else begin b_start = 1'b1; b_len = 8'(len); end
    word_ready = 1'b1;
    for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
      @(negedge clock);
      a_start = 1'b0; b_start = 1'b0;
      a_len = 7'(len); b_len = 8'(len);
      if (c_read_en) nreads++;
      if (want_done) begin
        checks++;
        if (c_done !== 1'b1 || c_busy !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse L=%0d: done=%b busy=%b, required done=1 busy=0", len, c_done, c_busy);
        end
        finished = 1'b1;
      end else begin
        if (c_done) ndone++;
        if (c_word_valid && first_lat < 0) first_lat = cyc;
        if (abort_at == nwords && c_word_valid) begin
          reset = 1'b0;
          #1;
          checks++;
          if ({a_read_en, a_read_address, a_word_valid, a_word_data, a_word_index,
               a_block_last, a_busy, a_done, a_len_error} !== '0) begin
            errors++;
            $display("FAIL reset_midrun_a: valid=%b data=%h idx=%0d busy=%b rd=%b, required all 0",
                     a_word_valid, a_word_data, a_word_index, a_busy, a_read_en);
          end
          @(negedge clock);
          reset = 1'b1;
          finished = 1'b1;
        end else begin
          if (stall_at == nwords && c_word_valid && stall_left > 0) begin
            word_ready = 1'b0;
            if (stall_left == 10) held = c_word_data;
            else begin
              checks++;
              if (c_word_data !== held || c_word_valid !== 1'b1 || c_read_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: data=%h valid=%b rd=%b, required data=%h valid=1 rd=0",
                         c_word_data, c_word_valid, c_read_en, held);
              end
            end
            if (stall_left == 5 && which == 0) begin a_start = 1'b1; a_len = 7'd1; end
            stall_left--;
          end else begin
            word_ready = 1'b1;
          end
          if (c_word_valid && word_ready) begin
            checks++;
            if (nwords >= total / 4) begin
              errors++;
              $display("FAIL extra_word L=%0d: word %0d beyond %0d words", len, nwords, total / 4);
              finished = 1'b1;
            end else begin
              exp_word = {pad[4*nwords], pad[4*nwords+1], pad[4*nwords+2], pad[4*nwords+3]};
              if (c_word_data !== exp_word || c_word_index !== 4'(nwords)
                  || c_block_last !== (nwords == total / 4 - 1)) begin
                errors++;
                $display("FAIL word L=%0d #%0d: data=%h idx=%0d last=%b, required data=%h idx=%0d last=%b",
                         len, nwords, c_word_data, c_word_index, c_block_last,
                         exp_word, nwords % 16, (nwords == total / 4 - 1));
              end
              got_word[nwords] = c_word_data;
              got_idx[nwords]  = c_word_index;
              nwords++;
              if (c_block_last) want_done = 1'b1;
            end
          end
        end
      end
    end
    word_ready = 1'b1;
    if (!finished) begin
      errors++;
      $display("FAIL timeout L=%0d: %0d words seen, stream did not complete", len, nwords);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({a_read_en, a_read_address, a_word_valid, a_word_data, a_word_index, a_block_last,
         a_busy, a_done, a_len_error, b_read_en, b_read_address, b_word_valid, b_word_data,
         b_word_index, b_block_last, b_busy, b_done, b_len_error} !== '0) begin
      errors++;
      $display("FAIL reset_state: a_busy=%b a_valid=%b b_busy=%b b_valid=%b, required all outputs 0",
               a_busy, a_word_valid, b_busy, b_word_valid);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_abc();
    run_stream(0, 3, -1, -1);
    checks++;
    if (nwords !== 16 || got_word[0] !== 32'h61626380 || got_word[15] !== 32'h00000018) begin
      errors++;
      $display("FAIL abc_words: n=%0d w0=%h w15=%h, required n=16 w0=61626380 w15=00000018",
               nwords, got_word[0], got_word[15]);
    end
    checks++;
    if (nreads !== 3 || ndone !== 0 || first_lat !== 6) begin
      errors++;
      $display("FAIL abc_timing: reads=%0d stray_done=%0d latency=%0d, required 3 0 6",
               nreads, ndone, first_lat);
    end
  endtask

  task automatic test_empty();
    run_stream(0, 0, -1, -1);
    checks++;
    if (nwords !== 16 || got_word[0] !== 32'h80000000 || got_word[15] !== 32'h0 || nreads !== 0) begin
      errors++;
      $display("FAIL empty: n=%0d w0=%h w15=%h reads=%0d, required 16 80000000 00000000 0",
               nwords, got_word[0], got_word[15], nreads);
    end
  endtask

  task automatic test_max_len();
    run_stream(0, 55, -1, -1);
    checks++;
    if (nwords !== 16 || got_word[13] !== 32'h95969780 || got_word[14] !== 32'h0
        || got_word[15] !== 32'h000001B8 || nreads !== 55) begin
      errors++;
      $display("FAIL max_len: n=%0d w13=%h w14=%h w15=%h reads=%0d, required 16 95969780 0 000001b8 55",
               nwords, got_word[13], got_word[14], got_word[15], nreads);
    end
  endtask

  task automatic test_two_block();
    run_stream(1, 56, -1, -1);
    checks++;
    if (nwords !== 32 || got_word[13] !== 32'h95969798 || got_word[14] !== 32'h80000000
        || got_word[31] !== 32'h000001C0 || nreads !== 56) begin
      errors++;
      $display("FAIL two_block: n=%0d w13=%h w14=%h w31=%h reads=%0d, required 32 95969798 80000000 000001c0 56",
               nwords, got_word[13], got_word[14], got_word[31], nreads);
    end
    checks++;
    if (got_idx[15] !== 4'd15 || got_idx[16] !== 4'd0 || got_idx[31] !== 4'd15) begin
      errors++;
      $display("FAIL index_wrap: idx15=%0d idx16=%0d idx31=%0d, required 15 0 15",
               got_idx[15], got_idx[16], got_idx[31]);
    end
  endtask

  task automatic test_backpressure();
    run_stream(0, 20, 5, -1);
    checks++;
    if (nwords !== 16 || got_word[4] !== 32'h71727374 || got_word[5] !== 32'h80000000
        || got_word[15] !== 32'h000000A0 || nreads !== 20) begin
      errors++;
      $display("FAIL backpressure: n=%0d w4=%h w5=%h w15=%h reads=%0d, required 16 71727374 80000000 000000a0 20",
               nwords, got_word[4], got_word[5], got_word[15], nreads);
    end
  endtask

  task automatic test_len_error();
    @(negedge clock);
    a_start = 1'b1; a_len = 7'd56;
    b_start = 1'b1; b_len = 8'd120;
    @(negedge clock);
    a_start = 1'b0; b_start = 1'b0;
    checks++;
    if (a_len_error !== 1'b1 || a_busy !== 1'b0 || b_len_error !== 1'b1 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL len_error_pulse: a_err=%b a_busy=%b b_err=%b b_busy=%b, required 1 0 1 0",
               a_len_error, a_busy, b_len_error, b_busy);
    end
    @(negedge clock);
    checks++;
    if (a_len_error !== 1'b0 || a_busy !== 1'b0 || a_read_en !== 1'b0 || b_len_error !== 1'b0) begin
      errors++;
      $display("FAIL len_error_clear: a_err=%b a_busy=%b a_rd=%b b_err=%b, required 0 0 0 0",
               a_len_error, a_busy, a_read_en, b_len_error);
    end
  endtask

  task automatic test_reset_midrun();
    run_stream(0, 10, -1, 7);
    run_stream(0, 10, -1, -1);
    checks++;
    if (nwords !== 16 || got_word[0] !== 32'h61626364 || got_word[2] !== 32'h696A8000
        || got_word[15] !== 32'h00000050 || nreads !== 10) begin
      errors++;
      $display("FAIL after_reset: n=%0d w0=%h w2=%h w15=%h reads=%0d, required 16 61626364 696a8000 00000050 10",
               nwords, got_word[0], got_word[2], got_word[15], nreads);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(32'h61 + i);
    a_start = 1'b0; b_start = 1'b0; a_len = 7'd0; b_len = 8'd0; word_ready = 1'b1;
    test_reset();
    test_abc();
    test_empty();
    test_max_len();
    test_two_block();
    test_backpressure();
    test_len_error();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
